// File: rtl/shadow_stack_ctrl.sv
// Shadow-stack sequencer: owns the SSP, bounds-checks push/pop-check/set,
// issues single-beat data-cache requests and reports completion or exception.
module shadow_stack_ctrl #(
    parameter int unsigned     XLEN          = 64,
    parameter int unsigned     TRANS_ID_BITS = 3,
    parameter logic [XLEN-1:0] SSP_RESET     = '0,
    parameter int unsigned     SLOT_BYTES    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [1:0]               cmd_op_i,
    input  logic [XLEN-1:0]          cmd_data_i,
    input  logic [TRANS_ID_BITS-1:0] cmd_trans_id_i,
    input  logic [XLEN-1:0]          ss_base_i,
    input  logic [XLEN-1:0]          ss_limit_i,
    output logic                     mem_req_o,
    input  logic                     mem_gnt_i,
    output logic                     mem_we_o,
    output logic [XLEN-1:0]          mem_addr_o,
    output logic [XLEN-1:0]          mem_wdata_o,
    input  logic                     mem_rvalid_i,
    input  logic [XLEN-1:0]          mem_rdata_i,
    output logic                     done_valid_o,
    output logic [TRANS_ID_BITS-1:0] done_trans_id_o,
    output logic                     ex_valid_o,
    output logic [1:0]               ex_cause_o,
    output logic [XLEN-1:0]          ssp_o
);

    localparam logic [1:0] OP_PUSH   = 2'b00;
    localparam logic [1:0] OP_POPCHK = 2'b01;
    localparam logic [1:0] OP_SETSSP = 2'b10;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b00;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'b01;
    localparam logic [1:0] CAUSE_UNDERFLOW = 2'b10;
    localparam logic [1:0] CAUSE_MISMATCH = 2'b11;

    localparam logic [XLEN:0]   SLOT_X     = (XLEN+1)'(SLOT_BYTES);
    localparam logic [XLEN-1:0] SLOT_W     = XLEN'(SLOT_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = SLOT_W - XLEN'(1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_REQ, ST_WAIT_RESP, ST_DONE, ST_DRAIN
    } state_t;

    state_t state, state_next;

    logic [XLEN-1:0]          ssp_q;
    logic [1:0]               op_q;
    logic [XLEN-1:0]          data_q;
    logic [XLEN-1:0]          addr_q;
    logic [TRANS_ID_BITS-1:0] id_q;
    logic                     ex_q;
    logic [1:0]               cause_q;

    logic            accept;
    logic [XLEN:0]   push_addr_x;
    logic [XLEN:0]   pop_end_x;
    logic            push_ovf;
    logic            pop_unf;
    logic            set_misalign;
    logic            resp_take;

    // Bounds are evaluated one bit wider so a wrap below zero or past the top counts as out of range.
    assign accept       = (state == ST_IDLE) && cmd_valid_i;
    assign push_addr_x  = {1'b0, ssp_q} - SLOT_X;
    assign pop_end_x    = {1'b0, ssp_q} + SLOT_X;
    assign push_ovf     = push_addr_x[XLEN] || (push_addr_x[XLEN-1:0] < ss_base_i);
    assign pop_unf      = pop_end_x > {1'b0, ss_limit_i};
    assign set_misalign = |(cmd_data_i & ALIGN_MASK);
    assign resp_take    = (state == ST_WAIT_RESP) && mem_rvalid_i && !flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    unique case (cmd_op_i)
                        OP_PUSH:   state_next = push_ovf ? ST_DONE : ST_REQ;
                        OP_POPCHK: state_next = pop_unf  ? ST_DONE : ST_REQ;
                        default:   state_next = ST_DONE;
                    endcase
                end
            end
            // A grant seen together with a flush still owes a response, so it must be drained.
            ST_REQ: begin
                if (mem_gnt_i)    state_next = flush_i ? ST_DRAIN : ST_WAIT_RESP;
                else if (flush_i) state_next = ST_IDLE;
            end
            ST_WAIT_RESP: begin
                if (mem_rvalid_i) state_next = flush_i ? ST_IDLE : ST_DONE;
                else if (flush_i) state_next = ST_DRAIN;
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_DRAIN: begin
                if (mem_rvalid_i) state_next = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Command capture and SSP update; only the SSP is architectural state needing reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ssp_q <= SSP_RESET;
        end else begin
            if (accept) begin
                op_q   <= cmd_op_i;
                data_q <= cmd_data_i;
                id_q   <= cmd_trans_id_i;
                addr_q <= (cmd_op_i == OP_PUSH) ? push_addr_x[XLEN-1:0] : ssp_q;
                unique case (cmd_op_i)
                    OP_PUSH: begin
                        ex_q    <= push_ovf;
                        cause_q <= CAUSE_OVERFLOW;
                    end
                    OP_POPCHK: begin
                        ex_q    <= pop_unf;
                        cause_q <= CAUSE_UNDERFLOW;
                    end
                    OP_SETSSP: begin
                        ex_q    <= set_misalign;
                        cause_q <= CAUSE_MISALIGN;
                        if (!set_misalign) ssp_q <= cmd_data_i;
                    end
                    default: begin
                        ex_q    <= 1'b0;
                        cause_q <= CAUSE_MISALIGN;
                    end
                endcase
            end
            if (resp_take) begin
                if (op_q == OP_PUSH) begin
                    ssp_q <= addr_q;
                end else if (mem_rdata_i == data_q) begin
                    ssp_q <= ssp_q + SLOT_W;
                end else begin
                    ex_q    <= 1'b1;
                    cause_q <= CAUSE_MISMATCH;
                end
            end
        end
    end

    always_comb begin
        cmd_ready_o     = (state == ST_IDLE);
        mem_req_o       = (state == ST_REQ);
        mem_we_o        = 1'b0;
        mem_addr_o      = '0;
        mem_wdata_o     = '0;
        done_valid_o    = 1'b0;
        done_trans_id_o = '0;
        ex_valid_o      = 1'b0;
        ex_cause_o      = '0;
        if (state == ST_REQ) begin
            mem_we_o    = (op_q == OP_PUSH);
            mem_addr_o  = addr_q;
            mem_wdata_o = (op_q == OP_PUSH) ? data_q : '0;
        end
        if (state == ST_DONE && !flush_i) begin
            done_valid_o    = 1'b1;
            done_trans_id_o = id_q;
            ex_valid_o      = ex_q;
            ex_cause_o      = ex_q ? cause_q : 2'b00;
        end
    end

    assign ssp_o = ssp_q;

endmodule
